// File: rtl/minmax_requester_if.sv
// Bundle of sample-stream, comparator and result-port signals for minmax_requester.
// The master modport is the requester; the slave modport is its surroundings
// (sample producer, sorting comparator and result consumer).
//
// Handshake rule for both streams (S_* and R_*): a word transfers on a rising
// CLK edge where VALID and READY are both high. Once VALID is raised, the
// source holds it and its payload stable until that edge. READY may be raised
// or dropped freely and never depends on the same cycle's VALID.
interface minmax_requester_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8
);
    logic                             S_VALID;
    logic                             S_READY;
    logic [DATA_WIDTH-1:0]            S_DATA;
    logic                             S_MODE;

    logic                             CMP_RST_N;
    logic                             CMP_MODE;
    logic [DATA_WIDTH*NUM_INPUTS-1:0] CMP_DIN;
    logic [DATA_WIDTH-1:0]            CMP_DOUT;
    logic                             CMP_DONE;

    logic                             R_VALID;
    logic                             R_READY;
    logic [DATA_WIDTH-1:0]            R_DATA;
    logic                             R_MODE;
    logic                             R_ERR;

    modport master (
        input  S_VALID, S_DATA, S_MODE, CMP_DOUT, CMP_DONE, R_READY,
        output S_READY, CMP_RST_N, CMP_MODE, CMP_DIN, R_VALID, R_DATA, R_MODE, R_ERR
    );

    modport slave (
        output S_VALID, S_DATA, S_MODE, CMP_DOUT, CMP_DONE, R_READY,
        input  S_READY, CMP_RST_N, CMP_MODE, CMP_DIN, R_VALID, R_DATA, R_MODE, R_ERR
    );
endinterface

// File: rtl/minmax_requester.sv
// minmax_requester: gathers NUM_INPUTS samples into the comparator's parallel
// bus, releases the comparator from reset for exactly one sort, captures the
// result and offers it on a valid/ready result port.
// Optional build macro CMP_TIMEOUT_EN adds a WAIT-state watchdog that gives up
// after TIMEOUT_CYCLES cycles and returns R_DATA = 0 with R_ERR = 1.
module minmax_requester #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_INPUTS     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               CLK,
    input  logic               RST_N,
    minmax_requester_if.master bus,
    output logic [1:0]         dbg_state
);

    localparam int CW = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_ARM    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [CW-1:0]                    count;
    logic                             cmp_rst_n_q;
    logic                             cmp_mode_q;
    logic [DATA_WIDTH*NUM_INPUTS-1:0] cmp_din_q;
    logic                             r_valid_q;
    logic [DATA_WIDTH-1:0]            r_data_q;
    logic                             r_mode_q;
    logic                             r_err_q;

    logic s_fire;
    logic r_fire;
    logic last_word;
    logic timeout_hit;

    // S_READY is gated by RST_N so it drops the instant reset is asserted.
    assign bus.S_READY = (state == ST_FILL) && RST_N;
    assign s_fire      = bus.S_VALID && bus.S_READY;
    assign r_fire      = r_valid_q && bus.R_READY;
    assign last_word   = (count == CW'(NUM_INPUTS - 1));

    assign bus.CMP_RST_N = cmp_rst_n_q;
    assign bus.CMP_MODE  = cmp_mode_q;
    assign bus.CMP_DIN   = cmp_din_q;
    assign bus.R_VALID   = r_valid_q;
    assign bus.R_DATA    = r_data_q;
    assign bus.R_MODE    = r_mode_q;
    assign bus.R_ERR     = r_err_q;
    assign dbg_state     = state;

`ifdef CMP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Watchdog: counts cycles spent in WAIT, cleared in every other state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (state != ST_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th WAIT cycle; CMP_DONE in that cycle still wins.
    assign timeout_hit = (state == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // TIMEOUT_CYCLES has no role without the watchdog; WAIT holds until CMP_DONE.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
    assign timeout_hit           = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: FILL -> ARM -> WAIT -> RESULT -> FILL.
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL:   if (s_fire && last_word) state_next = ST_ARM;
            ST_ARM:    state_next = ST_WAIT;
            ST_WAIT:   if (bus.CMP_DONE || timeout_hit) state_next = ST_RESULT;
            ST_RESULT: if (r_fire) state_next = ST_FILL;
            default:   state_next = ST_FILL;
        endcase
    end

    // Batch capture: write each accepted sample into its slot, latch mode on word 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count      <= '0;
            cmp_mode_q <= 1'b0;
            cmp_din_q  <= '0;
        end else if ((state == ST_FILL) && s_fire) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (count == CW'(k)) begin
                    cmp_din_q[k*DATA_WIDTH +: DATA_WIDTH] <= bus.S_DATA;
                end
            end
            if (count == '0) begin
                cmp_mode_q <= bus.S_MODE;
            end
            count <= last_word ? '0 : count + CW'(1);
        end
    end

    // Comparator release and result port: CMP_RST_N is high only during WAIT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_rst_n_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_mode_q    <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    cmp_rst_n_q <= 1'b1;
                end
                ST_WAIT: begin
                    if (bus.CMP_DONE) begin
                        r_data_q    <= bus.CMP_DOUT;
                        r_mode_q    <= cmp_mode_q;
                        r_err_q     <= 1'b0;
                        r_valid_q   <= 1'b1;
                        cmp_rst_n_q <= 1'b0;
                    end else if (timeout_hit) begin
                        r_data_q    <= '0;
                        r_mode_q    <= cmp_mode_q;
                        r_err_q     <= 1'b1;
                        r_valid_q   <= 1'b1;
                        cmp_rst_n_q <= 1'b0;
                    end
                end
                ST_RESULT: begin
                    if (r_fire) begin
                        r_valid_q <= 1'b0;
                    end
                end
                default: begin
                    cmp_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
